// File: rtl/cnn_maxpool.sv
// cnn_maxpool -- 2x2, stride-2 max-pooling engine.
//
// Reads a row-major feature map from the conv output memory (synchronous read,
// data one cycle after the address) and writes the pooled, row-major result
// into the input data memory. Each window takes exactly five cycles
// (RD0..RD3 issue addresses, WR emits the result), with no gaps between windows.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   maxp_en       start pulse, sampled in IDLE only
//   fm_w, fm_h    source feature-map dimensions, latched at start
//   out_rd        conv output memory read data
//   maxp_out_ra   conv output memory read address
//   maxp_in_we    input memory write enable
//   maxp_in_wa    input memory write address
//   maxp_in_wd    input memory write data
//   maxp_busy     high whenever not IDLE
//   maxp_done     one-cycle completion pulse
module cnn_maxpool #(
    parameter int DATA_SIZE = 16,
    parameter int MEM_SIZE  = 12,
    parameter int DIM_SIZE  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 maxp_en,
    input  logic [DIM_SIZE-1:0]  fm_w,
    input  logic [DIM_SIZE-1:0]  fm_h,
    input  logic [DATA_SIZE-1:0] out_rd,
    output logic [MEM_SIZE-1:0]  maxp_out_ra,
    output logic                 maxp_in_we,
    output logic [MEM_SIZE-1:0]  maxp_in_wa,
    output logic [DATA_SIZE-1:0] maxp_in_wd,
    output logic                 maxp_busy,
    output logic                 maxp_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_RD2,
        S_RD3,
        S_WR,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [MEM_SIZE-1:0]          fw_q, fw_d;     // latched source width
    logic [DIM_SIZE-1:0]          ow_q, ow_d;     // output width
    logic [DIM_SIZE-1:0]          oh_q, oh_d;     // output height
    logic [DIM_SIZE-1:0]          i_q, i_d;       // output row
    logic [DIM_SIZE-1:0]          j_q, j_d;       // output column
    logic [MEM_SIZE-1:0]          row_q, row_d;   // 2*i*fw
    logic [MEM_SIZE-1:0]          base_q, base_d; // 2*i*fw + 2*j
    logic [MEM_SIZE-1:0]          dst_q, dst_d;   // i*ow + j
    logic signed [DATA_SIZE-1:0]  acc_q, acc_d;

    logic [DIM_SIZE-1:0]          ow_in, oh_in;
    logic [MEM_SIZE-1:0]          fw2;
    logic [MEM_SIZE-1:0]          row_next;
    logic signed [DATA_SIZE-1:0]  rd_s;
    logic signed [DATA_SIZE-1:0]  max_rd;
    logic                         last_col, last_row;

    function automatic logic signed [DATA_SIZE-1:0] smax(
        input logic signed [DATA_SIZE-1:0] a,
        input logic signed [DATA_SIZE-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign ow_in    = fm_w >> 1;
    assign oh_in    = fm_h >> 1;
    assign fw2      = {fw_q[MEM_SIZE-2:0], 1'b0};
    assign row_next = row_q + fw2;
    assign rd_s     = $signed(out_rd);
    assign max_rd   = smax(acc_q, rd_s);
    assign last_col = (j_q == ow_q - DIM_SIZE'(1));
    assign last_row = (i_q == oh_q - DIM_SIZE'(1));

    always_comb begin
        state_d     = state_q;
        fw_d        = fw_q;
        ow_d        = ow_q;
        oh_d        = oh_q;
        i_d         = i_q;
        j_d         = j_q;
        row_d       = row_q;
        base_d      = base_q;
        dst_d       = dst_q;
        acc_d       = acc_q;
        maxp_out_ra = '0;
        maxp_in_we  = 1'b0;
        maxp_in_wa  = '0;
        maxp_in_wd  = '0;
        maxp_done   = 1'b0;
        maxp_busy   = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (maxp_en) begin
                    fw_d   = MEM_SIZE'(fm_w);
                    ow_d   = ow_in;
                    oh_d   = oh_in;
                    i_d    = '0;
                    j_d    = '0;
                    row_d  = '0;
                    base_d = '0;
                    dst_d  = '0;
                    acc_d  = '0;
                    state_d = (ow_in == '0 || oh_in == '0) ? S_DONE : S_RD0;
                end
            end
            S_RD0: begin
                maxp_out_ra = base_q;
                state_d     = S_RD1;
            end
            S_RD1: begin
                maxp_out_ra = base_q + MEM_SIZE'(1);
                acc_d       = rd_s;
                state_d     = S_RD2;
            end
            S_RD2: begin
                maxp_out_ra = base_q + fw_q;
                acc_d       = max_rd;
                state_d     = S_RD3;
            end
            S_RD3: begin
                maxp_out_ra = base_q + fw_q + MEM_SIZE'(1);
                acc_d       = max_rd;
                state_d     = S_WR;
            end
            S_WR: begin
                // Fourth sample arrives this cycle, so the write data is the
                // combinational max against the accumulator.
                maxp_out_ra = base_q + fw_q + MEM_SIZE'(1);
                maxp_in_we  = 1'b1;
                maxp_in_wa  = dst_q;
                maxp_in_wd  = max_rd;
                dst_d       = dst_q + MEM_SIZE'(1);
                if (last_col) begin
                    j_d    = '0;
                    i_d    = i_q + DIM_SIZE'(1);
                    row_d  = row_next;
                    base_d = row_next;
                end else begin
                    j_d    = j_q + DIM_SIZE'(1);
                    base_d = base_q + MEM_SIZE'(2);
                end
                state_d = (last_col && last_row) ? S_DONE : S_RD0;
            end
            S_DONE: begin
                maxp_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fw_q    <= '0;
            ow_q    <= '0;
            oh_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            row_q   <= '0;
            base_q  <= '0;
            dst_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            fw_q    <= fw_d;
            ow_q    <= ow_d;
            oh_q    <= oh_d;
            i_q     <= i_d;
            j_q     <= j_d;
            row_q   <= row_d;
            base_q  <= base_d;
            dst_q   <= dst_d;
            acc_q   <= acc_d;
        end
    end

endmodule
